// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// Provides default geometry, the address type and the zero-register address.
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_WORDS = 32;
  localparam int DEF_AW    = $clog2(DEF_WORDS);

  typedef logic [DEF_AW-1:0] addr_t;

  localparam addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reserve sets, any write clears, reserve wins.
// Ports: clk_i/reset_i, w_en_i/w_addr_i, rsv_en_i/rsv_addr_i, busy_q_o, busy_d_o.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WORDS    = DEF_WORDS,
  parameter int AW       = $clog2(WORDS),
  parameter int NW       = 1,
  parameter int ZERO_REG = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [NW-1:0]    w_en_i,
  input  logic [NW*AW-1:0] w_addr_i,
  input  logic             rsv_en_i,
  input  logic [AW-1:0]    rsv_addr_i,
  output logic [WORDS-1:0] busy_q_o,
  output logic [WORDS-1:0] busy_d_o
);

  logic [WORDS-1:0] busy_q;
  logic [WORDS-1:0] busy_d;
  logic [AW-1:0]    wa;

  always_comb begin
    busy_d = busy_q;
    wa     = '0;
    for (int k = 0; k < NW; k++) begin
      wa = w_addr_i[k*AW +: AW];
      if (w_en_i[k] && int'(wa) < WORDS)
        busy_d[wa] = 1'b0;
    end
    // applied after the clears so a new producer overrides a retiring one
    if (rsv_en_i && int'(rsv_addr_i) < WORDS)
      busy_d[rsv_addr_i] = 1'b1;
    if (ZERO_REG != 0)
      busy_d[int'(ZERO_ADDR)] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_q_o = busy_q;
  assign busy_d_o = busy_d;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered, write-first forwarded reads.
// Ports: clk, reset, w_en/w_addr/w_data, r_addr/r_data/r_busy, rsv_en/rsv_addr, busy_all.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int WORDS    = DEF_WORDS,
  localparam int AW      = $clog2(WORDS),
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NW-1:0]       w_en,
  input  logic [NW*AW-1:0]    w_addr,
  input  logic [NW*WIDTH-1:0] w_data,
  input  logic [NR*AW-1:0]    r_addr,
  output logic [NR*WIDTH-1:0] r_data,
  output logic [NR-1:0]       r_busy,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [WORDS-1:0]    busy_all
);

  logic [WIDTH-1:0]    mem_q [WORDS];
  logic [WIDTH-1:0]    mem_d [WORDS];
  logic [NR*WIDTH-1:0] r_data_q, r_data_d;
  logic [NR-1:0]       r_busy_q, r_busy_d;
  logic [WORDS-1:0]    busy_d;
  logic [AW-1:0]       wa;
  logic [AW-1:0]       ra;

  regfile_scoreboard #(
    .WORDS   (WORDS),
    .AW      (AW),
    .NW      (NW),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk_i     (clk),
    .reset_i   (reset),
    .w_en_i    (w_en),
    .w_addr_i  (w_addr),
    .rsv_en_i  (rsv_en),
    .rsv_addr_i(rsv_addr),
    .busy_q_o  (busy_all),
    .busy_d_o  (busy_d)
  );

  // Reads index the next-state array, which gives write-first forwarding;
  // higher-numbered write ports are applied last and so win collisions.
  always_comb begin
    mem_d    = mem_q;
    r_data_d = '0;
    r_busy_d = '0;
    wa       = '0;
    ra       = '0;
    for (int k = 0; k < NW; k++) begin
      wa = w_addr[k*AW +: AW];
      if (w_en[k] && int'(wa) < WORDS)
        mem_d[wa] = w_data[k*WIDTH +: WIDTH];
    end
    if (ZERO_REG != 0)
      mem_d[int'(ZERO_ADDR)] = '0;
    for (int i = 0; i < NR; i++) begin
      ra = r_addr[i*AW +: AW];
      if (int'(ra) < WORDS) begin
        r_data_d[i*WIDTH +: WIDTH] = mem_d[ra];
        r_busy_d[i]                = busy_d[ra];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      r_data_q <= '0;
      r_busy_q <= '0;
    end else begin
      mem_q    <= mem_d;
      r_data_q <= r_data_d;
      r_busy_q <= r_busy_d;
    end
  end

  assign r_data = r_data_q;
  assign r_busy = r_busy_q;

endmodule
